// File: rtl/dm9000_bus_ctrl_if.sv
// Host-request, response and DM9000 pin bundle for dm9000_bus_ctrl.
// Handshake: a request transfers on a clk edge where req_valid && req_ready; rsp_valid is a one-cycle completion pulse.
interface dm9000_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        eth_cs_n;
  logic        eth_cmd;
  logic        eth_ior_n;
  logic        eth_iow_n;
  logic [15:0] eth_data_o;
  logic        eth_data_oe;
  logic [15:0] eth_data_i;
  logic        eth_int;
  logic        irq;
  logic [2:0]  fsm_state;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, eth_data_i, eth_int,
    output req_ready, rsp_valid, rsp_rdata, busy, eth_cs_n, eth_cmd,
           eth_ior_n, eth_iow_n, eth_data_o, eth_data_oe, irq, fsm_state
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, eth_data_i, eth_int,
    input  req_ready, rsp_valid, rsp_rdata, busy, eth_cs_n, eth_cmd,
           eth_ior_n, eth_iow_n, eth_data_o, eth_data_oe, irq, fsm_state
  );
endinterface

// File: rtl/dm9000_bus_ctrl.sv
// DM9000 register-access bus controller: index cycle then data cycle, each as setup / strobe / gap.
// All pin outputs are registered from the next-state so strobes are glitch-free and state-aligned.
module dm9000_bus_ctrl #(
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 2,
  parameter int T_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_key,
  dm9000_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IDX_SETUP  = 3'd1,
    IDX_STROBE = 3'd2,
    IDX_GAP    = 3'd3,
    DAT_SETUP  = 3'd4,
    DAT_STROBE = 3'd5,
    DAT_GAP    = 3'd6
  } state_t;

  localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
  localparam logic [3:0] LD_GAP   = 4'(T_GAP - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        we_q, we_n;
  logic [7:0]  addr_q, addr_n;
  logic [15:0] wdata_q, wdata_n;
  logic [15:0] rdata_q;
  logic        accept;
  logic        last;

  logic        cs_n_q, cmd_q, ior_n_q, iow_n_q, oe_q, rv_q;
  logic [15:0] data_q;
  logic        cs_n_d, cmd_d, ior_n_d, iow_n_d, oe_d, rv_d;
  logic [15:0] data_d;
  logic        idx_n, dat_n;

  logic        int_meta, int_sync;

  assign accept = (state == IDLE) && bus.req_valid;
  assign last   = (cnt == 4'd0);

  // Request fields as they will be held after this edge; lets outputs register on the accept edge.
  assign we_n    = accept ? bus.req_we    : we_q;
  assign addr_n  = accept ? bus.req_addr  : addr_q;
  assign wdata_n = accept ? bus.req_wdata : wdata_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_n = IDX_SETUP;
          cnt_n   = LD_SETUP;
        end
      end
      default: begin
        if (!last) begin
          cnt_n = cnt - 4'd1;
        end else begin
          case (state)
            IDX_SETUP:  begin state_n = IDX_STROBE; cnt_n = LD_PULSE; end
            IDX_STROBE: begin state_n = IDX_GAP;    cnt_n = LD_GAP;   end
            IDX_GAP:    begin state_n = DAT_SETUP;  cnt_n = LD_SETUP; end
            DAT_SETUP:  begin state_n = DAT_STROBE; cnt_n = LD_PULSE; end
            DAT_STROBE: begin state_n = DAT_GAP;    cnt_n = LD_GAP;   end
            default:    begin state_n = IDLE;       cnt_n = 4'd0;     end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    idx_n   = (state_n == IDX_SETUP) || (state_n == IDX_STROBE) || (state_n == IDX_GAP);
    dat_n   = (state_n == DAT_SETUP) || (state_n == DAT_STROBE) || (state_n == DAT_GAP);
    cs_n_d  = (state_n == IDLE);
    cmd_d   = !idx_n;
    iow_n_d = !((state_n == IDX_STROBE) || ((state_n == DAT_STROBE) && we_n));
    ior_n_d = !((state_n == DAT_STROBE) && !we_n);
    oe_d    = idx_n || (dat_n && we_n);
    data_d  = 16'h0000;
    if (idx_n) begin
      data_d = {8'h00, addr_n};
    end else if (dat_n && we_n) begin
      data_d = wdata_n;
    end
    rv_d    = (state_n == DAT_GAP) && (cnt_n == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      cs_n_q  <= 1'b1;
      cmd_q   <= 1'b1;
      ior_n_q <= 1'b1;
      iow_n_q <= 1'b1;
      oe_q    <= 1'b0;
      data_q  <= 16'h0000;
      rv_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      // Read data is captured at the close of the final strobe cycle, while IOR# is still low.
      if ((state == DAT_STROBE) && last && !we_q) begin
        rdata_q <= bus.eth_data_i;
      end
      cs_n_q  <= cs_n_d;
      cmd_q   <= cmd_d;
      ior_n_q <= ior_n_d;
      iow_n_q <= iow_n_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      rv_q    <= rv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_meta <= bus.eth_int;
      int_sync <= int_meta;
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.eth_cs_n    = cs_n_q;
  assign bus.eth_cmd     = cmd_q;
  assign bus.eth_ior_n   = ior_n_q;
  assign bus.eth_iow_n   = iow_n_q;
  assign bus.eth_data_o  = data_q;
  assign bus.eth_data_oe = oe_q;
  assign bus.irq         = int_sync;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_dm9000_bus_ctrl.sv
// Directed bench for dm9000_bus_ctrl: per-cycle pin model, response scoreboard, reset abort, irq sync.
module tb_dm9000_bus_ctrl;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  logic [15:0] last_rd_a = 16'h0000;
  logic [15:0] last_rd_b = 16'h0000;
  localparam logic [23:0] IDLE_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};

  always #5 clk = ~clk;

  dm9000_bus_ctrl_if ia();
  dm9000_bus_ctrl_if ib();

  dm9000_bus_ctrl u_a (.clk(clk), .rst_key(rst_a), .bus(ia.slave));
  dm9000_bus_ctrl #(.T_SETUP(3), .T_PULSE(4), .T_GAP(1)) u_b (.clk(clk), .rst_key(rst_b), .bus(ib.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ready, busy, cs_n, cmd, ior_n, iow_n, oe, rsp_valid, data_o (only when driven)}
  function automatic logic [23:0] get_vec(input bit sel);
    if (sel)
      return {ib.req_ready, ib.busy, ib.eth_cs_n, ib.eth_cmd, ib.eth_ior_n, ib.eth_iow_n,
              ib.eth_data_oe, ib.rsp_valid, ib.eth_data_oe ? ib.eth_data_o : 16'h0000};
    return {ia.req_ready, ia.busy, ia.eth_cs_n, ia.eth_cmd, ia.eth_ior_n, ia.eth_iow_n,
            ia.eth_data_oe, ia.rsp_valid, ia.eth_data_oe ? ia.eth_data_o : 16'h0000};
  endfunction

  // Expected pins for cycle k after the accept edge (k = 1 is the first cycle).
  function automatic logic [23:0] exp_vec(input int ts, input int tp, input int tg, input int k,
                                          input bit we, input logic [7:0] addr, input logic [15:0] wdata);
    int p;
    int j;
    bit dat, stb;
    logic [15:0] d;
    p = ts + tp + tg;
    if (k > 2 * p) return IDLE_VEC;
    dat = (k > p);
    j   = dat ? k - p : k;
    stb = (j > ts) && (j <= ts + tp);
    d   = !dat ? {8'h00, addr} : (we ? wdata : 16'h0000);
    return {1'b0, 1'b1, 1'b0, dat, !(stb && dat && !we), !(stb && (!dat || we)),
            (!dat || we), (k == 2 * p), d};
  endfunction

  task automatic drive(input bit sel, input bit v, input bit we, input logic [7:0] addr,
                       input logic [15:0] wdata);
    if (sel) begin
      ib.req_valid = v; ib.req_we = we; ib.req_addr = addr; ib.req_wdata = wdata;
    end else begin
      ia.req_valid = v; ia.req_we = we; ia.req_addr = addr; ia.req_wdata = wdata;
    end
  endtask

  task automatic set_din(input bit sel, input logic [15:0] d);
    if (sel) ib.eth_data_i = d;
    else     ia.eth_data_i = d;
  endtask

  // Called at a negedge. Runs one transaction and checks every cycle through the following IDLE cycle.
  task automatic run_txn(input bit sel, input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                         input logic [15:0] din, input bit hold, output int waited);
    int ts, tp, tg, p;
    logic [15:0] e;
    ts = sel ? 3 : 1;
    tp = sel ? 4 : 2;
    tg = sel ? 1 : 2;
    p  = ts + tp + tg;
    drive(sel, 1'b1, we, addr, wdata);
    set_din(sel, din);
    if (sel) begin
      e = we ? last_rd_b : din;
      if (!we) last_rd_b = din;
      exp_q_b.push_back(e);
    end else begin
      e = we ? last_rd_a : din;
      if (!we) last_rd_a = din;
      exp_q_a.push_back(e);
    end
    waited = 0;
    while (!(sel ? ib.req_ready : ia.req_ready) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("accept_in_time_%0d", sel), 32'(waited < 40), 32'd1);
    if (waited >= 40) return;
    @(posedge clk);
    for (int k = 1; k <= 2 * p + 1; k++) begin
      @(negedge clk);
      check($sformatf("pins_%s_k%0d", sel ? "b" : "a", k), 32'(get_vec(sel)),
            32'(exp_vec(ts, tp, tg, k, we, addr, wdata)));
      if (k == 1 && !hold) drive(sel, 1'b0, !we, ~addr, ~wdata);
      if (k == p + ts + tp + 1 && !we) set_din(sel, 16'($urandom_range(0, 65535)));
    end
  endtask

  always @(negedge clk) begin
    if (ia.rsp_valid) begin
      check("rsp_a_expected", 32'(exp_q_a.size() != 0), 32'd1);
      if (exp_q_a.size() != 0) check("rsp_rdata_a", 32'(ia.rsp_rdata), 32'(exp_q_a.pop_front()));
    end
    if (ib.rsp_valid) begin
      check("rsp_b_expected", 32'(exp_q_b.size() != 0), 32'd1);
      if (exp_q_b.size() != 0) check("rsp_rdata_b", 32'(ib.rsp_rdata), 32'(exp_q_b.pop_front()));
    end
    check("strobe_rules_a", {30'd0, ia.eth_ior_n | ia.eth_iow_n, !(ia.eth_data_oe && !ia.eth_ior_n)}, 32'd3);
    check("strobe_rules_b", {30'd0, ib.eth_ior_n | ib.eth_iow_n, !(ib.eth_data_oe && !ib.eth_ior_n)}, 32'd3);
  end

  initial begin
    int w;
    logic [23:0] v;
    logic [15:0] r;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    ia.eth_data_i = 16'h0000; ia.eth_int = 1'b0;
    ib.eth_data_i = 16'h0000; ib.eth_int = 1'b0;
    repeat (3) @(negedge clk);
    v = get_vec(1'b0);
    check("reset_pins_a", 32'(v[22:0]), 32'(IDLE_VEC[22:0]));
    v = get_vec(1'b1);
    check("reset_pins_b", 32'(v[22:0]), 32'(IDLE_VEC[22:0]));
    check("reset_rdata_a", 32'(ia.rsp_rdata), 32'h0);
    check("reset_irq_a", 32'(ia.irq), 32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(ia.req_ready), 32'd1);
    @(negedge clk);

    run_txn(1'b0, 1'b1, 8'h1F, 16'h0001, 16'h0000, 1'b0, w);
    run_txn(1'b0, 1'b0, 8'h28, 16'h0000, 16'h0A46, 1'b0, w);

    // Back-to-back with req_valid held high across both requests.
    run_txn(1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 1'b1, w);
    r = 16'($urandom_range(0, 65535));
    run_txn(1'b0, 1'b0, 8'h11, 16'h0000, r, 1'b0, w);
    check("b2b_second_accept_wait", 32'(w), 32'd0);
    run_txn(1'b0, 1'b1, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 16'h0000, 1'b0, w);

    // Reset during DAT_STROBE of a write: no response, pins return idle at once.
    drive(1'b0, 1'b1, 1'b1, 8'h33, 16'h5555);
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    check("pre_reset_iow_low", 32'(ia.eth_iow_n), 32'd0);
    #1 rst_a = 1'b0;
    #1;
    v = get_vec(1'b0);
    check("abort_pins_idle", 32'(v[22:0]), 32'(IDLE_VEC[22:0]));
    check("abort_rdata_cleared", 32'(ia.rsp_rdata), 32'h0);
    last_rd_a = 16'h0000;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", 32'(ia.req_ready), 32'd1);
    @(negedge clk);
    run_txn(1'b0, 1'b0, 8'h05, 16'h0000, 16'h1234, 1'b0, w);

    // Stretched timing instance: 16-cycle transactions, 4-cycle strobes.
    run_txn(1'b1, 1'b1, 8'hA5, 16'hC3C3, 16'h0000, 1'b0, w);
    run_txn(1'b1, 1'b0, 8'h3C, 16'h0000, 16'h7E81, 1'b0, w);

    // 5-cycle interrupt pulse.
    ia.eth_int = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      check($sformatf("irq_m%0d", m), 32'(ia.irq), 32'((m >= 2) && (m <= 6)));
      if (m == 5) ia.eth_int = 1'b0;
    end

    repeat (2) @(negedge clk);
    check("queue_a_drained", 32'(exp_q_a.size()), 32'd0);
    check("queue_b_drained", 32'(exp_q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
